// File: rtl/tt_hsig_pkg.sv
// rtl/tt_hsig_pkg.sv - shared state encoding, link constants and frame-length helpers for the hsig host
package tt_hsig_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      TURN,
      RESP,
      DONE
   } hsig_state_e;

   localparam logic START_BIT = 1'b1;
   localparam logic ACK_OK    = 1'b1;

   function automatic int cmd_bits(input int addr_w, input int data_w, input bit write, input int par);
      return 2 + addr_w + (write ? data_w : 0) + par;
   endfunction

   function automatic int rsp_bits(input int data_w, input bit write, input int par);
      return 1 + (write ? 0 : data_w) + par;
   endfunction

   function automatic int frame_bits(input int addr_w, input int data_w, input int turn_bits,
                                     input bit write, input int par);
      return cmd_bits(addr_w, data_w, write, par) + turn_bits + rsp_bits(data_w, write, par);
   endfunction

endpackage

// File: rtl/tt_hsig_clkgen.sv
// rtl/tt_hsig_clkgen.sv - hclk phase counter with drive (first low cycle) and sample (last high cycle) strobes
module tt_hsig_clkgen
   import tt_hsig_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic hclk_o,
   output logic drive_stb_o,
   output logic sample_stb_o
);

   localparam int            PW      = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] ph_q, ph_d;
   logic          hi_q, hi_d;

   // Disabled counter parks at the start of a low phase so the next frame begins cleanly.
   always_comb begin
      ph_d = ph_q;
      hi_d = hi_q;
      if (!en_i) begin
         ph_d = '0;
         hi_d = 1'b0;
      end else if (ph_q == PH_LAST) begin
         ph_d = '0;
         hi_d = ~hi_q;
      end else begin
         ph_d = ph_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q <= '0;
         hi_q <= 1'b0;
      end else begin
         ph_q <= ph_d;
         hi_q <= hi_d;
      end
   end

   assign hclk_o       = hi_q;
   assign drive_stb_o  = en_i & ~hi_q & (ph_q == '0);
   assign sample_stb_o = en_i & hi_q & (ph_q == PH_LAST);

endmodule

// File: rtl/tt_hsig_host.sv
// rtl/tt_hsig_host.sv - per-tile serial control link master; optional HSIG_PARITY_EN adds even-parity bits
module tt_hsig_host
   import tt_hsig_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int TURN_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              hclk_A,
   output logic              hclk_OE,
   output logic              hsig_A,
   output logic              hsig_OE,
   output logic              hsig_IE,
   output logic              hsig_PD,
   input  logic              hsig_Y
);

`ifdef HSIG_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CMD_W     = 2 + ADDR_W + DATA_W + PAR;
   localparam int WR_CMD    = cmd_bits(ADDR_W, DATA_W, 1'b1, PAR);
   localparam int RD_CMD    = cmd_bits(ADDR_W, DATA_W, 1'b0, PAR);
   localparam int WR_RSP    = rsp_bits(DATA_W, 1'b1, PAR);
   localparam int RD_RSP    = rsp_bits(DATA_W, 1'b0, PAR);
   localparam int WR_FRAME  = frame_bits(ADDR_W, DATA_W, TURN_BITS, 1'b1, PAR);
   localparam int RD_FRAME  = frame_bits(ADDR_W, DATA_W, TURN_BITS, 1'b0, PAR);
   localparam int FRAME_MAX = (WR_FRAME > RD_FRAME) ? WR_FRAME : RD_FRAME;
   localparam int BW        = $clog2(FRAME_MAX + 1);

   hsig_state_e       state_q, state_d;
   logic              xfer, clk_en, drive_stb, sample_stb;
   logic              wr_q, ack_q, ack_d, err_q, err_d, hclk_oe_q;
   logic [BW-1:0]     bit_q, cmd_end, turn_end, rsp_end;
   logic [CMD_W-1:0]  cmd_q, cmd_load;
   logic [DATA_W-1:0] data_q, data_d, rdata_q;
   logic              is_ack, is_data, cmd_last, turn_last, rsp_last;
`ifdef HSIG_PARITY_EN
   logic              par_q, par_d, cmd_par;
`endif

   tt_hsig_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk          (clk),
      .rst          (rst),
      .en_i         (clk_en),
      .hclk_o       (hclk_A),
      .drive_stb_o  (drive_stb),
      .sample_stb_o (sample_stb)
   );

   assign xfer = req_valid & req_ready;

   // bit_q counts bits begun, so at a sample strobe it holds the 1-based index of the current bit.
   always_comb begin
      cmd_end   = wr_q ? BW'(WR_CMD) : BW'(RD_CMD);
      turn_end  = cmd_end + BW'(TURN_BITS);
      rsp_end   = turn_end + (wr_q ? BW'(WR_RSP) : BW'(RD_RSP));
      is_ack    = (bit_q == turn_end + BW'(1));
      is_data   = !wr_q && (bit_q > turn_end + BW'(1)) && (bit_q <= turn_end + BW'(1 + DATA_W));
      cmd_last  = sample_stb && (state_q == CMD)  && (bit_q == cmd_end);
      turn_last = sample_stb && (state_q == TURN) && (bit_q == turn_end);
      rsp_last  = sample_stb && (state_q == RESP) && (bit_q == rsp_end);
      ack_d     = is_ack  ? hsig_Y : ack_q;
      data_d    = is_data ? {data_q[DATA_W-2:0], hsig_Y} : data_q;
`ifdef HSIG_PARITY_EN
      par_d     = par_q ^ hsig_Y;
      err_d     = (ack_d != ACK_OK) | par_d;
`else
      err_d     = (ack_d != ACK_OK);
`endif
   end

`ifdef HSIG_PARITY_EN
   // Reads carry the parity bit straight after the address; the unused data slots trail as zeros.
   always_comb begin
      cmd_par  = ^{req_write, req_addr, (req_write ? req_wdata : {DATA_W{1'b0}})};
      cmd_load = req_write ? {START_BIT, 1'b1, req_addr, req_wdata, cmd_par}
                           : {START_BIT, 1'b0, req_addr, cmd_par, {DATA_W{1'b0}}};
   end
`else
   always_comb begin
      cmd_load = req_write ? {START_BIT, 1'b1, req_addr, req_wdata}
                           : {START_BIT, 1'b0, req_addr, {DATA_W{1'b0}}};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer)      state_d = CMD;
         CMD:     if (cmd_last)  state_d = TURN;
         TURN:    if (turn_last) state_d = RESP;
         RESP:    if (rsp_last)  state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      hsig_OE   = 1'b0;
      hsig_A    = 1'b0;
      clk_en    = 1'b0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         CMD: begin
            clk_en  = 1'b1;
            hsig_OE = 1'b1;
            hsig_A  = cmd_q[CMD_W-1];
         end
         TURN:    clk_en    = 1'b1;
         RESP:    clk_en    = 1'b1;
         DONE:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= 1'b0;
         bit_q   <= '0;
         cmd_q   <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef HSIG_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (xfer) begin
         wr_q    <= req_write;
         bit_q   <= '0;
         cmd_q   <= cmd_load;
         data_q  <= '0;
         ack_q   <= 1'b0;
`ifdef HSIG_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (drive_stb) bit_q <= bit_q + BW'(1);
         if (sample_stb && state_q == CMD) cmd_q <= cmd_q << 1;
         if (sample_stb && state_q == RESP) begin
            ack_q  <= ack_d;
            data_q <= data_d;
`ifdef HSIG_PARITY_EN
            par_q  <= par_d;
`endif
         end
         if (rsp_last) begin
            rdata_q <= wr_q ? {DATA_W{1'b0}} : data_d;
            err_q   <= err_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) hclk_oe_q <= 1'b1;
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign hclk_OE   = hclk_oe_q;
   assign hsig_IE   = 1'b1;
   assign hsig_PD   = 1'b1;

endmodule

// File: tb/tb_tt_hsig_host.sv
// tb/tb_tt_hsig_host.sv - table-driven bench for tt_hsig_host with a cycle-counted tile model
module tb_tt_hsig_host;

   localparam int CLK_DIV   = 4;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 8;
   localparam int TURN_BITS = 2;
   localparam int BITP      = 2 * CLK_DIV;
`ifdef HSIG_PARITY_EN
   localparam int PAR    = 1;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int PAR    = 0;
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      bit              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      bit              ack;
      logic [DATA_W-1:0] tdata;
      bit              flip;
      logic [DATA_W-1:0] exp_rdata;
      bit              exp_err;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              hclk_A, hclk_OE, hsig_A, hsig_OE, hsig_IE, hsig_PD;
   logic              hsig_Y = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;
   vec_t vecs[9];

   tt_hsig_host #(
      .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TURN_BITS(TURN_BITS)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .hclk_A(hclk_A), .hclk_OE(hclk_OE), .hsig_A(hsig_A), .hsig_OE(hsig_OE),
      .hsig_IE(hsig_IE), .hsig_PD(hsig_PD), .hsig_Y(hsig_Y)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 400 && !req_ready; k++) tick();
      check("wait_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int cbits, rbase, rn, fbits, lat, tbad, rbusy, n, p;
      logic [31:0] ea, eo, aa, ao, rb;
      logic [DATA_W-1:0] got_rd;
      logic got_err, rdy_after;
      cbits = 2 + ADDR_W + (v.write ? DATA_W : 0) + PAR;
      rbase = cbits + TURN_BITS;
      rn    = 1 + (v.write ? 0 : DATA_W) + PAR;
      fbits = rbase + rn;
      ea = '0; eo = '0; aa = '0; ao = '0; rb = '0;
      ea[0] = 1'b1;
      ea[1] = v.write;
      for (int i = 0; i < ADDR_W; i++) ea[2+i] = v.addr[ADDR_W-1-i];
      if (v.write) for (int i = 0; i < DATA_W; i++) ea[2+ADDR_W+i] = v.wdata[DATA_W-1-i];
      if (PAR == 1) ea[cbits-1] = ^{v.write, v.addr, (v.write ? v.wdata : {DATA_W{1'b0}})};
      for (int i = 0; i < cbits; i++) eo[i] = 1'b1;
      rb[0] = v.ack;
      if (!v.write) for (int i = 0; i < DATA_W; i++) rb[1+i] = v.tdata[DATA_W-1-i];
      if (PAR == 1) rb[rn-1] = v.ack ^ (v.write ? 1'b0 : ^v.tdata) ^ v.flip;

      wait_ready();
      req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      lat = -1; tbad = 0; rbusy = 0; got_rd = '0; got_err = 1'b0; rdy_after = 1'b0;
      for (int c = 1; c <= fbits * BITP + 8; c++) begin
         n = (c - 1) / BITP;
         p = (c - 1) % BITP;
         hsig_Y = (n >= rbase && n < fbits) ? rb[n-rbase] : 1'b0;
         if (n < fbits) begin
            if (p == 0) begin
               aa[n] = hsig_A;
               ao[n] = hsig_OE;
            end else if (hsig_A !== aa[n] || hsig_OE !== ao[n]) tbad++;
            if (hclk_A !== (p >= CLK_DIV)) tbad++;
         end
         if (rsp_valid) begin
            lat = c - 1; got_rd = rsp_rdata; got_err = rsp_err;
            tick();
            rdy_after = req_ready & ~rsp_valid;
            break;
         end
         if (req_ready) rbusy++;
         tick();
      end
      hsig_Y = 1'b0;
      check($sformatf("v%0d_hsig_a", idx), aa, ea);
      check($sformatf("v%0d_hsig_oe", idx), ao, eo);
      check($sformatf("v%0d_bit_timing", idx), 32'(tbad), 32'd0);
      check($sformatf("v%0d_ready_low", idx), 32'(rbusy), 32'd0);
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(fbits * BITP));
      check($sformatf("v%0d_rsp_err", idx), 32'(got_err), 32'(v.exp_err));
      check($sformatf("v%0d_rsp_rdata", idx), 32'(got_rd), 32'(v.exp_rdata));
      check($sformatf("v%0d_ready_after", idx), 32'(rdy_after), 32'd1);
   endtask

   task automatic rst_mid(input int at);
      int nvalid;
      wait_ready();
      req_write = 1'b1; req_addr = 5'h13; req_wdata = 8'hA5; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c < at; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check($sformatf("rst%0d_hclk", at), 32'(hclk_A), 32'd0);
      check($sformatf("rst%0d_hsig_oe", at), 32'(hsig_OE), 32'd0);
      check($sformatf("rst%0d_hsig_a", at), 32'(hsig_A), 32'd0);
      check($sformatf("rst%0d_ready", at), 32'(req_ready), 32'd1);
      check($sformatf("rst%0d_rdata", at), 32'(rsp_rdata), 32'd0);
      nvalid = 0;
      for (int c = 0; c < 200; c++) begin
         if (rsp_valid) nvalid++;
         tick();
      end
      check($sformatf("rst%0d_no_rsp", at), 32'(nvalid), 32'd0);
   endtask

   task automatic back_to_back();
      int xfers, nrsp, rbad, x0, x1, tail, frame_clk;
      logic busy;
      frame_clk = (2 + ADDR_W + TURN_BITS + 1 + DATA_W + 2 * PAR) * BITP;
      wait_ready();
      req_write = 1'b0; req_addr = 5'h05; req_wdata = 8'h00; hsig_Y = 1'b0;
      req_valid = 1'b1;
      xfers = 0; nrsp = 0; rbad = 0; x0 = -1; x1 = -1; tail = -1; busy = 1'b0;
      for (int c = 0; c < 2 * (frame_clk + 2) + 20; c++) begin
         if (busy && req_ready) rbad++;
         if (rsp_valid) begin
            nrsp++;
            busy = 1'b0;
            if (nrsp == 2) begin
               req_valid = 1'b0;
               tail = 6;
            end
         end
         if (req_valid && req_ready) begin
            xfers++;
            busy = 1'b1;
            if (x0 < 0) x0 = c; else if (x1 < 0) x1 = c;
         end
         if (tail == 0) break;
         if (tail > 0) tail--;
         tick();
      end
      req_valid = 1'b0;
      check("b2b_transfers", 32'(xfers), 32'd2);
      check("b2b_responses", 32'(nrsp), 32'd2);
      check("b2b_ready_busy", 32'(rbad), 32'd0);
      check("b2b_interval", 32'(x1 - x0), 32'(frame_clk + 2));
   endtask

   initial begin
      //          write addr   wdata  ack tdata  flip exp_rdata exp_err
      vecs[0] = '{1'b1, 5'h13, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 5'h02, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
      vecs[2] = '{1'b0, 5'h1F, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{1'b0, 5'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{1'b1, 5'h1F, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{1'b0, 5'h11, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1};
      vecs[6] = '{1'b1, 5'h0A, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{1'b0, 5'h02, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C, PAR_EN};
      vecs[8] = '{1'b1, 5'h0C, 8'h81, 1'b1, 8'h00, 1'b1, 8'h00, PAR_EN};

      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("reset_hclk_a", 32'(hclk_A), 32'd0);
      check("reset_hsig_a", 32'(hsig_A), 32'd0);
      check("reset_hsig_oe", 32'(hsig_OE), 32'd0);
      check("reset_pad_consts", 32'({hclk_OE, hsig_IE, hsig_PD}), 32'h7);
      tick(); tick();
      check("idle_hclk_a", 32'(hclk_A), 32'd0);

      for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

      back_to_back();
      run_frame(vecs[3], 10);
      rst_mid(40);
      run_frame(vecs[1], 11);
      rst_mid(45);
      run_frame(vecs[0], 12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
